// File: rtl/tagger_cfg_master.sv
// tagger_cfg_master: register-bus initiator that writes a latched partition table into the tagger and commits it last
package tagger_cfg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module tagger_cfg_master
  import tagger_cfg_pkg::*;
#(
  parameter int unsigned MAXPARTITION = 2,
  parameter int unsigned PATID_LEN    = 8,
  parameter logic [31:0] REG_BASE     = 32'h0,
  parameter logic [31:0] COMMIT_OFS   = 32'h00,
  parameter logic [31:0] PATID_OFS    = 32'h04,
  parameter logic [31:0] CONF_OFS     = 32'h20,
  parameter logic [31:0] PAT_ADDR_OFS = 32'h40
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    cfg_valid_i,
  output logic                                    cfg_ready_o,
  input  logic [MAXPARTITION-1:0][33:0]           cfg_addr_i,
  input  logic [MAXPARTITION-1:0][PATID_LEN-1:0]  cfg_patid_i,
  input  logic [MAXPARTITION-1:0][1:0]            cfg_conf_i,
  output reg_req_t                                reg_req_o,
  input  reg_rsp_t                                reg_rsp_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    err_o
);
  localparam int unsigned NPR = 32 / PATID_LEN;
  localparam int unsigned NUM_PATID_REG = (MAXPARTITION + NPR - 1) / NPR;
  localparam int unsigned NUM_CONF_REG = (MAXPARTITION + 15) / 16;
  localparam logic [6:0] LAST_ADDR = 7'(MAXPARTITION - 1);
  localparam logic [6:0] LAST_PATID = 7'(NUM_PATID_REG - 1);
  localparam logic [6:0] LAST_CONF = 7'(NUM_CONF_REG - 1);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_PATID, WR_CONF, WR_COMMIT, DONE} state_t;

  state_t state_q, state_d, state_nx;
  logic [6:0] idx_q, idx_d, last;
  logic err_q, accept, hs, unused;
  logic [MAXPARTITION-1:0][33:0] addr_q;
  logic [MAXPARTITION-1:0][PATID_LEN-1:0] patid_q;
  logic [MAXPARTITION-1:0][1:0] conf_q;
  logic [127:0][31:0] addr_w, patid_w, conf_w;
  reg_req_t req;

  assign accept = cfg_valid_i && cfg_ready_o;
  assign hs = req.valid && reg_rsp_i.ready;
  assign unused = ^reg_rsp_i.rdata;
  assign cfg_ready_o = state_q == IDLE && !rst_i;
  assign reg_req_o = req;
  assign busy_o = req.valid;
  assign done_o = state_q == DONE;
  assign err_o = err_q;

  for (genvar k = 0; k < 128; k++) begin : g_addr
    if (k < MAXPARTITION) begin : g_used
      assign addr_w[k] = addr_q[k][33:2];
    end else begin : g_pad
      assign addr_w[k] = '0;
    end
  end

  for (genvar w = 0; w < 128; w++) begin : g_patid
    for (genvar m = 0; m < NPR; m++) begin : g_slot
      if (w * NPR + m < MAXPARTITION) begin : g_used
        assign patid_w[w][PATID_LEN*m +: PATID_LEN] = patid_q[w*NPR+m];
      end else begin : g_pad
        assign patid_w[w][PATID_LEN*m +: PATID_LEN] = '0;
      end
    end
    if (NPR * PATID_LEN < 32) begin : g_hi
      assign patid_w[w][31:NPR*PATID_LEN] = '0;
    end
  end

  for (genvar w = 0; w < 128; w++) begin : g_conf
    for (genvar m = 0; m < 16; m++) begin : g_slot
      if (w * 16 + m < MAXPARTITION) begin : g_used
        assign conf_w[w][2*m +: 2] = conf_q[w*16+m];
      end else begin : g_pad
        assign conf_w[w][2*m +: 2] = '0;
      end
    end
  end

  // capture the whole table on accept so the inputs may change during the sequence
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q <= cfg_addr_i;
      patid_q <= cfg_patid_i;
      conf_q <= cfg_conf_i;
    end
  end

  // state, write index and sticky error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      err_q <= accept ? 1'b0 : (hs && reg_rsp_i.error) ? 1'b1 : err_q;
    end
  end

  // request generation and sequencing; an error response jumps straight to DONE so no commit is issued
  always_comb begin
    req = '0;
    state_d = state_q;
    idx_d = idx_q;
    state_nx = state_q == WR_ADDR ? WR_PATID : state_q == WR_PATID ? WR_CONF :
               state_q == WR_CONF ? WR_COMMIT : DONE;
    last = state_q == WR_ADDR ? LAST_ADDR : state_q == WR_PATID ? LAST_PATID :
           state_q == WR_CONF ? LAST_CONF : 7'd0;
    case (state_q)
      IDLE: begin
        state_d = cfg_valid_i ? WR_ADDR : IDLE;
        idx_d = '0;
      end
      WR_ADDR: begin
        req.valid = 1'b1;
        req.addr = REG_BASE + PAT_ADDR_OFS + {23'd0, idx_q, 2'd0};
        req.wdata = addr_w[idx_q];
      end
      WR_PATID: begin
        req.valid = 1'b1;
        req.addr = REG_BASE + PATID_OFS + {23'd0, idx_q, 2'd0};
        req.wdata = patid_w[idx_q];
      end
      WR_CONF: begin
        req.valid = 1'b1;
        req.addr = REG_BASE + CONF_OFS + {23'd0, idx_q, 2'd0};
        req.wdata = conf_w[idx_q];
      end
      WR_COMMIT: begin
        req.valid = 1'b1;
        req.addr = REG_BASE + COMMIT_OFS;
        req.wdata = 32'h1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req.write = req.valid;
    req.wstrb = {4{req.valid}};
    if (hs) begin
      state_d = reg_rsp_i.error ? DONE : idx_q == last ? state_nx : state_q;
      idx_d = idx_q == last ? 7'd0 : idx_q + 7'd1;
    end
  end
endmodule

// File: tb/tb_tagger_cfg_master.sv
// tb_tagger_cfg_master: directed scoreboard bench for the tagger configuration writer
module tb_tagger_cfg_master;
  import tagger_cfg_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready, busy, done, err;
  logic [1:0][33:0] cfg_addr;
  logic [1:0][7:0] cfg_patid;
  logic [1:0][1:0] cfg_conf;
  reg_req_t req;
  reg_rsp_t rsp;

  logic cfg_valid5 = 1'b0, cfg_ready5, busy5, done5, err5;
  logic [4:0][33:0] cfg_addr5;
  logic [4:0][11:0] cfg_patid5;
  logic [4:0][1:0] cfg_conf5;
  reg_req_t req5;
  reg_rsp_t rsp5;

  wr_t exp_q[$];
  wr_t q5[$];
  int checks = 0, errors = 0, writes = 0;

  wr_t t1 [5] = '{64'h00000040_40000001, 64'h00000044_00000040, 64'h00000004_00003CA5,
                  64'h00000020_00000009, 64'h00000000_00000001};

  tagger_cfg_master dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_addr_i(cfg_addr), .cfg_patid_i(cfg_patid), .cfg_conf_i(cfg_conf),
    .reg_req_o(req), .reg_rsp_i(rsp), .busy_o(busy), .done_o(done), .err_o(err)
  );

  tagger_cfg_master #(.MAXPARTITION(5), .PATID_LEN(12)) dut5 (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid5), .cfg_ready_o(cfg_ready5),
    .cfg_addr_i(cfg_addr5), .cfg_patid_i(cfg_patid5), .cfg_conf_i(cfg_conf5),
    .reg_req_o(req5), .reg_rsp_i(rsp5), .busy_o(busy5), .done_o(done5), .err_o(err5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_t1(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(t1[i]);
  endtask

  task automatic take();
    wr_t e;
    writes++;
    chk("wr_attr", {req.write, req.wstrb}, 5'h1F);
    chk("wr_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_addr", req.addr, e.a);
      chk("wr_data", req.wdata, e.d);
    end
  endtask

  task automatic accept();
    @(negedge clk);
    cfg_valid = 1'b1;
    chk("cfg_ready_accept", cfg_ready, 1);
  endtask

  task automatic run(input int stall_hs, input int stall_n, input int err_hs, output int done_cyc);
    int hs = 0, stalled = 0;
    logic prev_stall = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    done_cyc = -1;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      rsp.ready = !(hs == stall_hs && stalled < stall_n);
      rsp.error = hs == err_hs;
      if (req.valid && !rsp.ready) stalled++;
      if (t == 1) chk("busy_first", busy, 1);
      if (prev_stall) begin
        chk("stall_addr", req.addr, pa);
        chk("stall_wdata", req.wdata, pd);
      end
      prev_stall = req.valid && !rsp.ready;
      pa = req.addr;
      pd = req.wdata;
      if (req.valid && rsp.ready) begin
        take();
        hs++;
      end
      if (done) begin
        done_cyc = t;
        chk("busy_at_done", busy, 0);
        break;
      end
    end
    rsp.ready = 1'b1;
    rsp.error = 1'b0;
  endtask

  initial begin
    int dc, acc, commits, vcount, d5;
    wr_t e;
    rsp = '0;
    rsp.ready = 1'b1;
    rsp5 = '0;
    rsp5.ready = 1'b1;
    cfg_addr = {34'h0_0000_0100, 34'h1_0000_0004};
    cfg_patid = {8'h3C, 8'hA5};
    cfg_conf = {2'b10, 2'b01};
    for (int k = 0; k < 5; k++) begin
      cfg_addr5[k] = 34'h2_0000_0000 + 34'(k * 32'h0101_0104);
      cfg_patid5[k] = 12'hA00 + 12'(k * 17);
      cfg_conf5[k] = 2'(k + 1);
    end
    cfg_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ctl", {req.valid, req.write, req.wstrb}, 0);
    chk("rst_req_addr", req.addr, 0);
    chk("rst_req_wdata", req.wdata, 0);
    chk("rst_flags", {busy, done, err, cfg_ready}, 0);
    cfg_valid = 1'b0;
    rst = 1'b0;

    accept();
    push_t1(5);
    run(-1, 0, -1, dc);
    chk("t1_done_cycle", dc, 6);
    chk("t1_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("t1_ready_again", cfg_ready, 1);

    accept();
    push_t1(5);
    run(2, 3, -1, dc);
    chk("stall_done_cycle", dc, 9);
    chk("stall_queue_empty", exp_q.size(), 0);
    @(negedge clk);

    accept();
    push_t1(2);
    run(-1, 0, 1, dc);
    chk("err_done_cycle", dc, 3);
    chk("err_flag", err, 1);
    chk("err_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("err_sticky_idle", err, 1);

    acc = 0;
    commits = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      cfg_valid = c < 20;
      if (cfg_valid && cfg_ready) begin
        acc++;
        push_t1(5);
      end
      if (c == 1) chk("err_cleared", err, 0);
      if (req.valid) begin
        if (req.addr == 32'h0) commits++;
        take();
      end
    end
    cfg_valid = 1'b0;
    chk("hold_accepts", acc, 3);
    chk("hold_commits", commits, 3);
    chk("hold_queue_empty", exp_q.size(), 0);

    accept();
    push_t1(3);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      if (t < 4 && req.valid) take();
      if (t == 4) begin
        chk("rst_mid_in_conf", req.addr, 32'h20);
        rst = 1'b1;
        rsp.ready = 1'b0;
      end
    end
    @(negedge clk);
    chk("rst_mid_valid", req.valid, 0);
    chk("rst_mid_done", done, 0);
    rst = 1'b0;
    rsp.ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", cfg_ready, 1);
    vcount = 0;
    for (int t = 0; t < 10; t++) begin
      if (req.valid || done) vcount++;
      @(negedge clk);
    end
    chk("rst_mid_no_commit", vcount, 0);
    chk("rst_mid_queue_empty", exp_q.size(), 0);

    for (int k = 0; k < 5; k++) q5.push_back({32'h40 + 32'(4 * k), cfg_addr5[k][33:2]});
    for (int w = 0; w < 3; w++) begin
      e = '0;
      e.a = 32'h04 + 32'(4 * w);
      for (int m = 0; m < 2; m++) if (w * 2 + m < 5) e.d[12*m +: 12] = cfg_patid5[w*2+m];
      q5.push_back(e);
    end
    e = '0;
    e.a = 32'h20;
    for (int k = 0; k < 5; k++) e.d[2*k +: 2] = cfg_conf5[k];
    q5.push_back(e);
    q5.push_back({32'h0, 32'h1});
    @(negedge clk);
    cfg_valid5 = 1'b1;
    chk("p5_ready", cfg_ready5, 1);
    d5 = -1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      cfg_valid5 = 1'b0;
      if (req5.valid) begin
        chk("p5_expected", q5.size() > 0, 1);
        if (q5.size() > 0) begin
          e = q5.pop_front();
          chk("p5_addr", req5.addr, e.a);
          chk("p5_data", req5.wdata, e.d);
        end
        if (req5.addr >= 32'h04 && req5.addr <= 32'h0C) chk("p5_patid_hi", req5.wdata[31:24], 0);
        if (req5.addr == 32'h0C) chk("p5_entry4", req5.wdata, {20'h0, cfg_patid5[4]});
      end
      if (done5) begin
        d5 = t;
        break;
      end
    end
    chk("p5_done_cycle", d5, 11);
    chk("p5_queue_empty", q5.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tagger_cfg_master.md
# tagger_cfg_master

Register-bus initiator that programs the transaction tagger's configuration registers from a parallel partition table. On each accepted table it issues the pat_addr, patid, addr_conf and pat_commit writes, with the commit write last, so the tagger's hardware table updates atomically. It sits between a host-side or boot-time configuration source and the tagger's register port, acting as the writer end of that register interface.

## Interface
- MAXPARTITION, 2, number of partitions (1..64)
- PATID_LEN, 8, partition ID width in bits (1..32)
- REG_BASE, 32'h0, byte base address of the tagger register block
- COMMIT_OFS, 32'h00, byte offset of pat_commit
- PATID_OFS, 32'h04, byte offset of patid word 0; word i is at PATID_OFS+4*i
- CONF_OFS, 32'h20, byte offset of addr_conf word 0; word i is at CONF_OFS+4*i
- PAT_ADDR_OFS, 32'h40, byte offset of pat_addr 0; entry k is at PAT_ADDR_OFS+4*k
- reg_req_t, logic, register request struct with fields addr, write, wdata, wstrb, valid
- reg_rsp_t, logic, register response struct with fields rdata, error, ready
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cfg_valid_i  in  1  table valid
- cfg_ready_o  out  1  table accept; high only in IDLE with rst_i low
- cfg_addr_i  in  MAXPARTITION x 34  per-partition boundary byte address
- cfg_patid_i  in  MAXPARTITION x PATID_LEN  per-partition ID
- cfg_conf_i  in  MAXPARTITION x 2  per-partition mode
- reg_req_o  out  reg_req_t  register request toward the tagger
- reg_rsp_i  in  reg_rsp_t  register response
- busy_o  out  1  high from table accept until done_o
- done_o  out  1  one-cycle pulse at the end of a sequence
- err_o  out  1  sticky error flag; cleared on the next table accept

## Operation
- Derived constants:
  - NPR = 32/PATID_LEN (integer division)
  - NUM_PATID_REG = ceil(MAXPARTITION/NPR)
  - NUM_CONF_REG = ceil(MAXPARTITION/16)
  - N = MAXPARTITION + NUM_PATID_REG + NUM_CONF_REG + 1
- Table accept: when cfg_valid_i && cfg_ready_o, all cfg_* inputs are latched into internal registers. Inputs are don't-care afterwards.
- FSM states: IDLE -> WR_ADDR -> WR_PATID -> WR_CONF -> WR_COMMIT -> DONE -> IDLE. An index counter runs inside each WR_* state.
- WR_ADDR, k = 0..MAXPARTITION-1: addr = REG_BASE+PAT_ADDR_OFS+4k, wdata = cfg_addr[k][33:2]. Bits [1:0] are dropped because the tagger works at 4-byte granularity.
- WR_PATID, word w: entry j = w*NPR+m is placed at bits [PATID_LEN*m +: PATID_LEN]. Unused upper bits are zero. Slots with j >= MAXPARTITION are zero.
- WR_CONF, word w: entry k = 16w+m is placed at bits [2m +: 2]. Slots with k >= MAXPARTITION are zero.
- WR_COMMIT: addr = REG_BASE+COMMIT_OFS, wdata = 32'h1.
- All requests use write=1 and wstrb=4'hF.
- Handshake:
  - valid is held with addr and wdata stable until ready is sampled high.
  - Only one request is outstanding at a time.
  - The next request is presented in the cycle after ready (back-to-back; valid may stay high).
- Error handling: if rsp.error=1 together with ready, the FSM sets err_o, skips every remaining write including the commit, and goes to DONE. The tagger table stays unchanged.
- DONE: done_o=1 and busy_o=0 for one cycle, then the FSM returns to IDLE.

## Timing
- Reset values, from the edge where rst_i=1 and held while it stays high:
  - FSM is in IDLE
  - reg_req_o is all zero
  - busy_o=0, done_o=0, err_o=0, cfg_ready_o=0
- Reset mid-sequence: the sequence aborts at the next edge. No commit is issued and no done_o pulse occurs.
- With reg_rsp_i.ready tied to 1 and the table accepted in cycle 0:
  - the first request is valid in cycle 1
  - the commit request is valid in cycle N
  - done_o pulses in cycle N+1
  - cfg_ready_o is high in cycle N+2
- Each ready-low cycle extends the sequence by exactly one cycle.
- cfg_valid_i while busy: not accepted and ignored; cfg_ready_o=0.
- Address arithmetic is 32-bit and wraps modulo 2^32.

## Test plan
- MAXPARTITION=2, PATID_LEN=8, ready=1. Table: addr {34'h1_0000_0004, 34'h0_0000_0100}, patid {8'hA5, 8'h3C}, conf {2'b01, 2'b10}. Expected 5 writes in this order:
  - 0x40 <= 32'h4000_0001
  - 0x44 <= 32'h0000_0040
  - 0x04 <= 32'h0000_3CA5
  - 0x20 <= 32'h0000_0009
  - 0x00 <= 32'h1
  - done_o in cycle 6
- Same table with ready low for 3 cycles on the patid write: addr and wdata stay stable during the stall, done_o moves to cycle 9, and the write order is unchanged.
- rsp.error=1 on the second pat_addr write: err_o=1, no writes to 0x04, 0x20 or 0x00, and done_o one cycle later.
- rst_i asserted during WR_CONF: reg_req_o.valid=0 at the next edge, no commit write ever appears, and cfg_ready_o=1 one cycle after rst_i drops.
- MAXPARTITION=5, PATID_LEN=12: NPR=2, so 3 patid words. Entry 4 goes in word 2 bits [11:0], and bits [31:24] of every patid word are zero.
- cfg_valid_i held high for 20 cycles: exactly one sequence per accept, a second sequence starts after IDLE, and err_o from a previous error is cleared on the new accept.
